// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 1280x1024@60 timing constants and load-request FSM encoding
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 1280;
  localparam int VGA_H_FP     = 48;
  localparam int VGA_H_SYNC   = 112;
  localparam int VGA_H_BP     = 248;
  localparam int VGA_V_ACTIVE = 1024;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 3;
  localparam int VGA_V_BP     = 38;
  localparam int VGA_REQ_HOLD = 8;
  localparam int CNT_W        = 11;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int VGA_H_TOTAL = line_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL = line_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

  typedef logic [CNT_W-1:0] cnt_t;

  // Shared with the loader so both sides agree on what the request strobe means.
  typedef enum logic {
    REQ_IDLE   = 1'b0,
    REQ_ASSERT = 1'b1
  } req_state_t;

endpackage

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - h/v scan counters with active, sync, vblank-start and line-start strobes
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [CNT_W-1:0] o_v_count,
  output logic             o_active,
  output logic             o_hs,
  output logic             o_vs,
  output logic             o_vblank_start,
  output logic             o_line_start
);

  localparam int   H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int   V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t HS_BEG  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t VS_BEG  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t r_h_count;
  cnt_t r_v_count;

  // Reset parks the scan at the top of vertical blank so line 0 is preloaded first.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_h_count <= '0;
      r_v_count <= V_ACT;
    end else if (r_h_count == H_LAST) begin
      r_h_count <= '0;
      r_v_count <= (r_v_count == V_LAST) ? '0 : r_v_count + 11'd1;
    end else begin
      r_h_count <= r_h_count + 11'd1;
    end
  end

  assign o_v_count      = r_v_count;
  assign o_active       = (r_h_count < H_ACT) && (r_v_count < V_ACT);
  assign o_hs           = (r_h_count >= HS_BEG) && (r_h_count < HS_END);
  assign o_vs           = (r_v_count >= VS_BEG) && (r_v_count < VS_END);
  assign o_vblank_start = (r_h_count == '0) && (r_v_count == V_ACT);
  assign o_line_start   = (r_h_count == '0);

endmodule

// File: rtl/fifo_to_vga_scanout.sv
// rtl/fifo_to_vga_scanout.sv - VGA scan-out from a show-ahead line FIFO with line-ahead load requests
module fifo_to_vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int REQ_HOLD = VGA_REQ_HOLD
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  output logic [12:0] oVGA_LINE_TO_LOAD,
  output logic        oVGA_LOAD_TO_FIFO_REQ,
  output logic        oVBLANK_START,
  input  logic [7:0]  iFIFO_RDATA,
  input  logic        iFIFO_EMPTY,
  output logic        oFIFO_REN,
  output logic        oFIFO_ACLR,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oVGA_SYNC_N,
  output logic        oUNDERFLOW,
  output logic [15:0] oUNDERFLOW_COUNT
);

  localparam int         V_TOTAL     = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam cnt_t       V_PRE_LIMIT = cnt_t'(V_ACTIVE - 1);
  localparam cnt_t       V_LAST      = cnt_t'(V_TOTAL - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(REQ_HOLD - 1);

  logic       w_active;
  logic       w_hs;
  logic       w_vs;
  logic       w_vblank_start;
  logic       w_line_start;
  cnt_t       w_v_count;

  vga_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .i_clk          (iCLK),
    .i_rst_n        (iRST_N),
    .o_v_count      (w_v_count),
    .o_active       (w_active),
    .o_hs           (w_hs),
    .o_vs           (w_vs),
    .o_vblank_start (w_vblank_start),
    .o_line_start   (w_line_start)
  );

  req_state_t r_req_state;
  req_state_t w_req_state_nxt;
  logic [3:0] r_hold_cnt;
  logic [3:0] w_hold_cnt_nxt;
  cnt_t       r_line;
  logic       w_trigger;
  cnt_t       w_line_nxt;

  // The last active line requests nothing; the last blank line preloads line 0.
  assign w_trigger  = w_line_start && ((w_v_count < V_PRE_LIMIT) || (w_v_count == V_LAST));
  assign w_line_nxt = (w_v_count == V_LAST) ? '0 : w_v_count + 11'd1;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_req_state <= REQ_IDLE;
      r_hold_cnt  <= '0;
    end else begin
      r_req_state <= w_req_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_req_state_nxt = r_req_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    unique case (r_req_state)
      REQ_IDLE: begin
        if (w_trigger) begin
          w_req_state_nxt = REQ_ASSERT;
          w_hold_cnt_nxt  = '0;
        end
      end
      REQ_ASSERT: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_req_state_nxt = REQ_IDLE;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_line <= '0;
    end else if (w_trigger) begin
      r_line <= w_line_nxt;
    end
  end

  logic       w_pop;
  logic       w_uf_event;
  logic [7:0] r_pix;
  logic       r_blank_n;
  logic       r_hs;
  logic       r_vs;
  logic       r_vbs;
  logic       r_aclr;
  logic       r_first;
  logic       r_underflow;
  logic [15:0] r_uf_count;

  assign w_pop      = w_active && !iFIFO_EMPTY;
  assign w_uf_event = w_active && iFIFO_EMPTY;

  // r_first stretches the clear one cycle past reset release.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_pix       <= '0;
      r_blank_n   <= 1'b0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_vbs       <= 1'b0;
      r_aclr      <= 1'b1;
      r_first     <= 1'b1;
      r_underflow <= 1'b0;
      r_uf_count  <= '0;
    end else begin
      r_pix     <= w_pop ? iFIFO_RDATA : 8'd0;
      r_blank_n <= w_active;
      r_hs      <= w_hs;
      r_vs      <= w_vs;
      r_vbs     <= w_vblank_start;
      r_first   <= 1'b0;
      r_aclr    <= r_first || (w_vblank_start && r_underflow);
      if (w_uf_event) begin
        r_underflow <= 1'b1;
      end else if (r_vbs) begin
        r_underflow <= 1'b0;
      end
      if (w_uf_event && (r_uf_count != 16'hFFFF)) begin
        r_uf_count <= r_uf_count + 16'd1;
      end
    end
  end

  assign oFIFO_REN             = iRST_N && w_pop;
  assign oVGA_LOAD_TO_FIFO_REQ = (r_req_state == REQ_ASSERT);
  assign oVGA_LINE_TO_LOAD     = {2'b00, r_line};
  assign oVBLANK_START         = r_vbs;
  assign oFIFO_ACLR            = r_aclr;
  assign oVGA_R                = r_pix;
  assign oVGA_G                = r_pix;
  assign oVGA_B                = r_pix;
  assign oVGA_HS               = r_hs;
  assign oVGA_VS               = r_vs;
  assign oVGA_BLANK_N          = r_blank_n;
  assign oVGA_SYNC_N           = 1'b0;
  assign oUNDERFLOW            = r_underflow;
  assign oUNDERFLOW_COUNT      = r_uf_count;

endmodule

// File: tb/tb_fifo_to_vga_scanout.sv
// tb/tb_fifo_to_vga_scanout.sv - scoreboard bench for fifo_to_vga_scanout on a shrunken raster
module tb_fifo_to_vga_scanout;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 4, HT = HA + HFP + HSY + HBP;
  localparam int VA = 8, VFP = 1, VSY = 3, VBP = 2, VT = VA + VFP + VSY + VBP;
  localparam int RH = 8;
  localparam int UF_LINE = 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty;
  logic [12:0] line_to_load;
  logic        load_req, vblank_start, fifo_ren, fifo_aclr;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, underflow;
  logic [15:0] underflow_count;

  always #5 clk = ~clk;

  fifo_to_vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .REQ_HOLD(RH)
  ) dut (
    .iCLK                  (clk),
    .iRST_N                (rstn),
    .oVGA_LINE_TO_LOAD     (line_to_load),
    .oVGA_LOAD_TO_FIFO_REQ (load_req),
    .oVBLANK_START         (vblank_start),
    .iFIFO_RDATA           (fifo_rdata),
    .iFIFO_EMPTY           (fifo_empty),
    .oFIFO_REN             (fifo_ren),
    .oFIFO_ACLR            (fifo_aclr),
    .oVGA_R                (vga_r),
    .oVGA_G                (vga_g),
    .oVGA_B                (vga_b),
    .oVGA_HS               (vga_hs),
    .oVGA_VS               (vga_vs),
    .oVGA_BLANK_N          (vga_blank_n),
    .oVGA_SYNC_N           (vga_sync_n),
    .oUNDERFLOW            (underflow),
    .oUNDERFLOW_COUNT      (underflow_count)
  );

  typedef struct {
    logic [7:0]  pix;
    logic        blank_n, hs, vs, vbs, req, aclr, uf, ren;
    logic [12:0] line;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  logic [7:0] ref_q[$];
  logic [7:0] env_q[$];
  logic [7:0] seed[VA];

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Signals sampled mid-cycle for the loader model, plus pulse tallies.
  logic        ren_s = 1'b0, req_s = 1'b0, aclr_s = 1'b0, req_q = 1'b0;
  logic [12:0] line_s = '0;
  logic        aclr_m = 1'b0, req_m = 1'b0;
  int dut_vbs_n = 0, dut_aclr_n = 0, dut_req_n = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    ren_s  = fifo_ren;
    req_s  = load_req;
    line_s = line_to_load;
    aclr_s = fifo_aclr;
    if (vblank_start === 1'b1) dut_vbs_n++;
    if (fifo_aclr === 1'b1 && !aclr_m) dut_aclr_n++;
    if (load_req === 1'b1 && !req_m) dut_req_n++;
    aclr_m = (fifo_aclr === 1'b1);
    req_m  = (load_req === 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pix_r", vga_r, e.pix);
      chk("pix_g", vga_g, e.pix);
      chk("pix_b", vga_b, e.pix);
      chk("blank_n", vga_blank_n, e.blank_n);
      chk("hs", vga_hs, e.hs);
      chk("vs", vga_vs, e.vs);
      chk("vblank_start", vblank_start, e.vbs);
      chk("load_req", load_req, e.req);
      chk("line_to_load", line_to_load, e.line);
      chk("aclr", fifo_aclr, e.aclr);
      chk("underflow", underflow, e.uf);
      chk("uf_count", underflow_count, e.cnt);
      chk("fifo_ren", fifo_ren, e.ren);
      chk("sync_n", vga_sync_n, 1'b0);
    end
  end

  // Reference model state: raster position seen by the DUT during the cycle just ended.
  int mh, mv, req_left, exp_line, vb_cnt, exp_req_n;
  int rst_left, uf_h, rst_h;
  logic first, last_vbs, uf, rst_applied, frc, rst_done, done;
  logic [15:0] ucnt;

  initial begin : driver
    exp_t e;
    logic act, vbs, ev, ac;
    logic [7:0] px;
    rstn = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0;
    foreach (seed[i]) seed[i] = 8'($urandom);
    uf_h = $urandom_range(0, HA - 10);
    rst_h = $urandom_range(2, HA + 4);
    mh = 0; mv = VA; req_left = 0; exp_line = 0; vb_cnt = 0; exp_req_n = 0;
    first = 1'b1; last_vbs = 1'b0; uf = 1'b0; ucnt = '0;
    rst_left = 3; rst_applied = 1'b0; frc = 1'b0; rst_done = 1'b0; done = 1'b0;

    while (!done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_applied) begin
        mh = 0; mv = VA; req_left = 0; exp_line = 0;
        first = 1'b1; last_vbs = 1'b0; uf = 1'b0; ucnt = '0;
        ref_q.delete();
        e = '{pix: 8'd0, blank_n: 1'b0, hs: 1'b0, vs: 1'b0, vbs: 1'b0, req: 1'b0,
              aclr: 1'b1, uf: 1'b0, ren: 1'b0, line: 13'd0, cnt: 16'd0};
      end else begin
        act = (mh < HA) && (mv < VA);
        vbs = (mh == 0) && (mv == VA);
        ev = 1'b0; px = 8'd0;
        if (act) begin
          if (frc || ref_q.size() == 0) ev = 1'b1;
          else px = ref_q.pop_front();
        end
        ac = first || (vbs && uf);
        if (ac) ref_q.delete();
        if (ev) uf = 1'b1;
        else if (last_vbs) uf = 1'b0;
        if (ev && ucnt != 16'hFFFF) ucnt = ucnt + 16'd1;
        if (req_left > 0) req_left--;
        if (mh == 0 && (mv < VA - 1 || mv == VT - 1)) begin
          exp_line = (mv == VT - 1) ? 0 : mv + 1;
          req_left = RH;
          exp_req_n++;
          for (int n = 0; n < HA; n++) ref_q.push_back(8'(n + int'(seed[exp_line])));
        end
        e.pix = px; e.blank_n = act; e.vbs = vbs; e.aclr = ac; e.uf = uf; e.cnt = ucnt;
        e.hs = (mh >= HA + HFP) && (mh < HA + HFP + HSY);
        e.vs = (mv >= VA + VFP) && (mv < VA + VFP + VSY);
        e.req = (req_left > 0);
        e.line = 13'(exp_line);
        first = 1'b0; last_vbs = vbs;
        if (vbs) vb_cnt++;
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end

      // Loader/FIFO environment reacting to what the DUT actually drove.
      if (aclr_s) begin
        env_q.delete();
      end else begin
        if (ren_s && env_q.size() > 0) void'(env_q.pop_front());
        if (req_s && !req_q && line_s < VA)
          for (int n = 0; n < HA; n++) env_q.push_back(8'(n + int'(seed[line_s])));
      end
      req_q = req_s;

      if (!rst_done && vb_cnt == 4 && mv == 3 && mh == rst_h) begin
        rst_left = 3;
        rst_done = 1'b1;
      end
      rstn = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      rst_applied = rstn;
      frc = rstn && ((vb_cnt == 3 && mv == UF_LINE && mh >= uf_h && mh < uf_h + 10) ||
                     (vb_cnt == 6 && mv == VA - 1 && mh == HA - 1));
      fifo_empty = (env_q.size() == 0) || frc;
      fifo_rdata = (env_q.size() > 0) ? env_q[0] : 8'($urandom);
      e.ren = rstn && (mh < HA) && (mv < VA) && !fifo_empty;
      sb.push_back(e);
      if (vb_cnt == 8 && mv == VA + 2) done = 1'b1;
    end

    if (!done) begin
      total++; bad++;
      $display("FAIL timeout cyc=%0d got=%0d want=%0d", cyc, vb_cnt, 8);
    end
    @(negedge clk); #1;
    chk("vbs_pulses", dut_vbs_n, vb_cnt);
    chk("aclr_pulses", dut_aclr_n, 4);
    chk("req_pulses", dut_req_n, exp_req_n);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
